// File: rtl/sram_ctrl_sync.sv
// sram_ctrl_sync: single-port asynchronous SRAM controller with a simple
// request/ready/ack host interface and a programmable strobe width.
//
// Optional feature: define SRAM_CTRL_B2B_EN to accept a same-direction
// request during HOLD, so consecutive accesses skip the IDLE cycle.
//
// Ports
//   iCLK, iRST            clock, synchronous active-high reset
//   iREQ, iWR             host request and direction (1 = write)
//   iADDR, iDATA, iBE     word address, write data, active-high byte enables
//   oREADY                a request presented now is taken at the next edge
//   oACK                  one-cycle completion pulse
//   oRDATA                read data, held until the next read completes
//   SRAM_DQ               bidirectional SRAM data bus
//   SRAM_ADDR, SRAM_BE_N  registered address and active-low byte lanes
//   SRAM_CE_N/OE_N/WE_N   registered active-low strobes
//
// state  | meaning
// IDLE   | waiting for a request, strobes released
// ACCESS | strobes asserted for WAIT_CYCLES+1 cycles
// HOLD   | strobes released, oACK pulses, write data still driven

module sram_ctrl_sync #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iREQ,
    input  logic                  iWR,
    input  logic [ADDR_W-1:0]     iADDR,
    input  logic [DATA_W-1:0]     iDATA,
    input  logic [DATA_W/8-1:0]   iBE,
    output logic                  oREADY,
    output logic                  oACK,
    output logic [DATA_W-1:0]     oRDATA,
    inout  wire  [DATA_W-1:0]     SRAM_DQ,
    output logic [ADDR_W-1:0]     SRAM_ADDR,
    output logic [DATA_W/8-1:0]   SRAM_BE_N,
    output logic                  SRAM_CE_N,
    output logic                  SRAM_OE_N,
    output logic                  SRAM_WE_N
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          cnt;
    logic                wr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                accept;
    logic                last_access;
    logic                dq_oe;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        oREADY      = 1'b0;
        oACK        = 1'b0;
        last_access = 1'b0;
        case (state)
            IDLE: begin
                oREADY = 1'b1;
                if (iREQ) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                last_access = (cnt == 4'd0);
                if (last_access) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // Gated by reset so an aborted transfer never acknowledges,
                // not even in the cycle reset is applied.
                oACK = !iRST;
`ifdef SRAM_CTRL_B2B_EN
                // Same direction only; a direction change needs the IDLE
                // cycle for bus turnaround.
                oREADY = (iWR == wr_q);
`endif
                state_nxt = IDLE;
                if (iREQ && oREADY) begin
                    state_nxt = ACCESS;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        accept = iREQ && oREADY;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cnt       <= 4'd0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            SRAM_ADDR <= '0;
            SRAM_BE_N <= '1;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            oRDATA    <= '0;
        end else if (accept) begin
            wr_q      <= iWR;
            wdata_q   <= iDATA;
            SRAM_ADDR <= iADDR;
            SRAM_BE_N <= ~iBE;
            SRAM_CE_N <= 1'b0;
            SRAM_OE_N <= iWR;
            SRAM_WE_N <= !iWR;
            cnt       <= 4'(WAIT_CYCLES);
        end else if (state == ACCESS) begin
            if (last_access) begin
                if (!wr_q) begin
                    oRDATA <= SRAM_DQ;
                end
                SRAM_CE_N <= 1'b1;
                SRAM_OE_N <= 1'b1;
                SRAM_WE_N <= 1'b1;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Write data stays on the bus through HOLD to give hold time after WE_N
    // rises. wdata_q only reloads at the next accept, so a back-to-back write
    // shows old data in HOLD and new data from its first ACCESS cycle.
    assign dq_oe   = wr_q && ((state == ACCESS) || (state == HOLD));
    assign SRAM_DQ = dq_oe ? wdata_q : 'z;

endmodule

// File: tb/tb_sram_ctrl_sync.sv
`timescale 1ns/1ps
module tb_sram_ctrl_sync;

    localparam int DW = 16;
    localparam int AW = 18;
    localparam int W  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, req, wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    be;
    logic          ready, ack;
    logic [DW-1:0] rdata;
    wire  [DW-1:0] dq;
    logic [AW-1:0] s_addr;
    logic [1:0]    s_be_n;
    logic          ce_n, oe_n, we_n;

    sram_ctrl_sync #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(W)) dut (
        .iCLK(clk), .iRST(rst), .iREQ(req), .iWR(wr), .iADDR(addr),
        .iDATA(data), .iBE(be), .oREADY(ready), .oACK(ack), .oRDATA(rdata),
        .SRAM_DQ(dq), .SRAM_ADDR(s_addr), .SRAM_BE_N(s_be_n),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n)
    );

    // Two extra instances with WAIT_CYCLES 0 and 3 for latency checks.
    logic          x_req [2];
    logic          x_ready [2];
    logic          x_ack [2];
    logic [DW-1:0] x_rdata [2];
    logic [AW-1:0] x_saddr [2];
    logic [1:0]    x_sbe_n [2];
    logic          x_ce_n [2], x_oe_n [2], x_we_n [2];
    wire  [DW-1:0] x_dq0, x_dq1;

    sram_ctrl_sync #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(0)) dut_w0 (
        .iCLK(clk), .iRST(rst), .iREQ(x_req[0]), .iWR(1'b1), .iADDR(18'h00004),
        .iDATA(16'h00FF), .iBE(2'b11), .oREADY(x_ready[0]), .oACK(x_ack[0]),
        .oRDATA(x_rdata[0]), .SRAM_DQ(x_dq0), .SRAM_ADDR(x_saddr[0]),
        .SRAM_BE_N(x_sbe_n[0]), .SRAM_CE_N(x_ce_n[0]), .SRAM_OE_N(x_oe_n[0]),
        .SRAM_WE_N(x_we_n[0])
    );

    sram_ctrl_sync #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(3)) dut_w3 (
        .iCLK(clk), .iRST(rst), .iREQ(x_req[1]), .iWR(1'b1), .iADDR(18'h00004),
        .iDATA(16'h00FF), .iBE(2'b11), .oREADY(x_ready[1]), .oACK(x_ack[1]),
        .oRDATA(x_rdata[1]), .SRAM_DQ(x_dq1), .SRAM_ADDR(x_saddr[1]),
        .SRAM_BE_N(x_sbe_n[1]), .SRAM_CE_N(x_ce_n[1]), .SRAM_OE_N(x_oe_n[1]),
        .SRAM_WE_N(x_we_n[1])
    );

    // SRAM model: drives the bus while CE_N and OE_N are low, writes enabled
    // bytes at every edge where CE_N and WE_N are low.
    logic [DW-1:0] sram [0:(1<<AW)-1];
    assign dq = (!ce_n && !oe_n) ? sram[s_addr] : 'z;
    always @(posedge clk) begin
        if (!ce_n && !we_n) begin
            for (int b = 0; b < 2; b++) begin
                if (!s_be_n[b]) sram[s_addr][b*8 +: 8] <= dq[b*8 +: 8];
            end
        end
    end

    // Reference memory and scoreboard.
    typedef struct {
        logic          wr;
        logic [DW-1:0] rd;
    } exp_t;

    logic [DW-1:0] ref_mem [int];
    exp_t          sb [$];
    logic [DW-1:0] last_rd;
    int            checks = 0;
    int            errors = 0;

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
    endfunction

    task automatic push(input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [1:0] b);
        exp_t          e;
        logic [DW-1:0] m;
        m = ref_read(a);
        if (w) begin
            for (int i = 0; i < 2; i++) if (b[i]) m[i*8 +: 8] = d[i*8 +: 8];
            ref_mem[int'(a)] = m;
        end
        e.wr = w;
        e.rd = m;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && !oe_n) begin
            checks++;
            if (dq !== ref_read(s_addr)) begin
                errors++;
                $display("FAIL dq_during_read addr=%h got=%h want=%h", s_addr, dq, ref_read(s_addr));
            end
        end
        if (ack) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack got=1 want=0 at %0t", $time);
            end else begin
                e = sb.pop_front();
                if (e.wr) begin
                    if (rdata !== last_rd) begin
                        errors++;
                        $display("FAIL rdata_on_write got=%h want=%h", rdata, last_rd);
                    end
                end else begin
                    if (rdata !== e.rd) begin
                        errors++;
                        $display("FAIL read_data got=%h want=%h", rdata, e.rd);
                    end
                    last_rd = e.rd;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request, waits (bounded) for ready, and returns one
    // cycle after the accepting edge with iREQ dropped.
    task automatic present(input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [1:0] b);
        int g;
        req = 1'b1; wr = w; addr = a; data = d; be = b;
        #1;
        g = 0;
        while (!ready && g < 50) begin
            step();
            #1;
            g++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout got=0 want=1");
        end else begin
            push(w, a, d, b);
        end
        step();
        req = 1'b0;
    endtask

    task automatic do_access(input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [1:0] b,
                             output int lat, output int stb,
                             output logic [AW-1:0] sa, output logic [1:0] sbe);
        present(w, a, d, b);
        lat = -1; stb = 0; sa = '0; sbe = '1;
        for (int n = 1; n <= 30; n++) begin
            if (n > 1) step();
            if (w ? !we_n : !oe_n) begin
                stb++;
                sa  = s_addr;
                sbe = s_be_n;
            end
            if (ack) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat, stb;
        logic [AW-1:0] sa;
        logic [1:0] sbe;
        rst = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; data = '0; be = '0;
        for (int k = 0; k < 2; k++) x_req[k] = 1'b0;
        step(); step();
        checks += 6;
        if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b want=1", ready); end
        if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b want=0", ack); end
        if ({ce_n, oe_n, we_n} !== 3'b111) begin errors++; $display("FAIL rst_strobes got=%b want=111", {ce_n, oe_n, we_n}); end
        if (s_be_n !== 2'b11) begin errors++; $display("FAIL rst_be_n got=%b want=11", s_be_n); end
        if (s_addr !== '0) begin errors++; $display("FAIL rst_addr got=%h want=0", s_addr); end
        if (rdata !== '0) begin errors++; $display("FAIL rst_rdata got=%h want=0", rdata); end
        req = 1'b1; wr = 1'b1; addr = 18'h00005; be = 2'b11;
        step();
        checks++;
        if (ce_n !== 1'b1) begin errors++; $display("FAIL req_during_rst ce_n got=%b want=1", ce_n); end
        rst = 1'b0;
        do_access(1'b1, 18'h00005, 16'h1234, 2'b11, lat, stb, sa, sbe);
        checks++;
        if (lat != W + 2) begin errors++; $display("FAIL first_after_rst latency got=%0d want=%0d", lat, W + 2); end
    endtask

    task automatic test_basic();
        int lat, stb;
        logic [AW-1:0] sa;
        logic [1:0] sbe;
        do_access(1'b1, 18'h00010, 16'hA5C3, 2'b11, lat, stb, sa, sbe);
        checks += 4;
        if (lat != W + 2) begin errors++; $display("FAIL wr_latency got=%0d want=%0d", lat, W + 2); end
        if (stb != W + 1) begin errors++; $display("FAIL we_n_width got=%0d want=%0d", stb, W + 1); end
        if (sa !== 18'h00010) begin errors++; $display("FAIL wr_addr got=%h want=00010", sa); end
        if (sbe !== 2'b00) begin errors++; $display("FAIL wr_be_n got=%b want=00", sbe); end
        step();
        checks++;
        if ({s_addr, s_be_n} !== {18'h00010, 2'b00}) begin
            errors++; $display("FAIL addr_hold got=%h/%b want=00010/00", s_addr, s_be_n);
        end
        do_access(1'b0, 18'h00010, 16'h0000, 2'b11, lat, stb, sa, sbe);
        checks += 3;
        if (lat != W + 2) begin errors++; $display("FAIL rd_latency got=%0d want=%0d", lat, W + 2); end
        if (stb != W + 1) begin errors++; $display("FAIL oe_n_width got=%0d want=%0d", stb, W + 1); end
        if (rdata !== 16'hA5C3) begin errors++; $display("FAIL rd_a5c3 got=%h want=a5c3", rdata); end
    endtask

    task automatic test_byte_enable();
        int lat, stb;
        logic [AW-1:0] sa;
        logic [1:0] sbe;
        do_access(1'b1, 18'h3FFFF, 16'hFFFF, 2'b11, lat, stb, sa, sbe);
        do_access(1'b1, 18'h3FFFF, 16'h1200, 2'b10, lat, stb, sa, sbe);
        checks += 2;
        if (sbe !== 2'b01) begin errors++; $display("FAIL be_partial got=%b want=01", sbe); end
        if (sa !== 18'h3FFFF) begin errors++; $display("FAIL addr_top got=%h want=3ffff", sa); end
        do_access(1'b0, 18'h3FFFF, 16'h0000, 2'b11, lat, stb, sa, sbe);
        checks++;
        if (rdata !== 16'h12FF) begin errors++; $display("FAIL rd_merge got=%h want=12ff", rdata); end
        do_access(1'b1, 18'h3FFFF, 16'hDEAD, 2'b00, lat, stb, sa, sbe);
        checks += 3;
        if (lat != W + 2) begin errors++; $display("FAIL be0_ack latency got=%0d want=%0d", lat, W + 2); end
        if (sbe !== 2'b11) begin errors++; $display("FAIL be0_be_n got=%b want=11", sbe); end
        if (stb != W + 1) begin errors++; $display("FAIL be0_strobe got=%0d want=%0d", stb, W + 1); end
        do_access(1'b0, 18'h3FFFF, 16'h0000, 2'b11, lat, stb, sa, sbe);
        checks++;
        if (rdata !== 16'h12FF) begin errors++; $display("FAIL be0_unchanged got=%h want=12ff", rdata); end
    endtask

    task automatic test_wait_params();
        int wk, lat, acks;
        for (int k = 0; k < 2; k++) begin
            wk = (k == 0) ? 0 : 3;
            lat = -1; acks = 0;
            x_req[k] = 1'b1;
            for (int n = 1; n <= 15; n++) begin
                step();
                if (x_ack[k]) begin
                    acks++;
                    if (lat < 0) lat = n;
                end
                // Keep iREQ high through ACCESS; it must not be queued.
                x_req[k] = (n <= wk + 1);
            end
            x_req[k] = 1'b0;
            checks += 2;
            if (lat != wk + 2) begin errors++; $display("FAIL wait%0d_latency got=%0d want=%0d", wk, lat, wk + 2); end
            if (acks != 1) begin errors++; $display("FAIL wait%0d_ack_count got=%0d want=1", wk, acks); end
        end
    endtask

    task automatic test_reset_abort();
        present(1'b1, 18'h00030, 16'hBEEF, 2'b11);
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL abort_acc_ack got=%b want=0", ack); end
        step();
        checks += 4;
        if ({ce_n, oe_n, we_n} !== 3'b111) begin errors++; $display("FAIL abort_strobes got=%b want=111", {ce_n, oe_n, we_n}); end
        if (ack !== 1'b0) begin errors++; $display("FAIL abort_ack_next got=%b want=0", ack); end
        if (s_be_n !== 2'b11) begin errors++; $display("FAIL abort_be_n got=%b want=11", s_be_n); end
        if (s_addr !== '0) begin errors++; $display("FAIL abort_addr got=%h want=0", s_addr); end
        rst = 1'b0;
        sb.delete();
        last_rd = '0;
        present(1'b0, 18'h00010, 16'h0000, 2'b11);
        for (int n = 2; n <= W + 2; n++) step();
        rst = 1'b1;
        #1;
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL abort_hold_ack got=%b want=0", ack); end
        step();
        checks += 2;
        if ({ce_n, oe_n, we_n} !== 3'b111) begin errors++; $display("FAIL abort_hold_strobes got=%b want=111", {ce_n, oe_n, we_n}); end
        if (rdata !== '0) begin errors++; $display("FAIL abort_rdata got=%h want=0", rdata); end
        rst = 1'b0;
        sb.delete();
        last_rd = '0;
    endtask

    task automatic test_back_to_back();
        int n, accepts, acks, exp_sp;
        int ack_cyc [5];
        logic gap_ce;
        n = 0; accepts = 0; acks = 0; gap_ce = 1'b0;
        be = 2'b11; data = 16'h5A5A;
        while (acks < 5 && n < 80) begin
            wr   = (accepts >= 4);
            req  = (accepts < 5);
            addr = wr ? 18'h00020 : 18'h00010;
            #1;
            if (req && ready) begin
                push(wr, addr, data, be);
                accepts++;
            end
            step();
            n++;
            if (ack) begin
                ack_cyc[acks] = n;
                acks++;
            end
            if (acks == 4 && n == ack_cyc[3] + 1) gap_ce = ce_n;
        end
        req = 1'b0;
        checks++;
        if (acks != 5) begin
            errors++; $display("FAIL b2b_timeout acks got=%0d want=5", acks);
        end else begin
            checks += 2;
            if (ack_cyc[0] != W + 2) begin errors++; $display("FAIL b2b_first_latency got=%0d want=%0d", ack_cyc[0], W + 2); end
            if (gap_ce !== 1'b1) begin errors++; $display("FAIL b2b_turnaround ce_n got=%b want=1", gap_ce); end
            for (int i = 0; i < 4; i++) begin
`ifdef SRAM_CTRL_B2B_EN
                exp_sp = (i < 3) ? W + 2 : W + 3;
`else
                exp_sp = W + 3;
`endif
                checks++;
                if (ack_cyc[i+1] - ack_cyc[i] != exp_sp) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d got=%0d want=%0d", i, ack_cyc[i+1] - ack_cyc[i], exp_sp);
                end
            end
        end
        for (int i = 0; i < 6; i++) step();
    endtask

    initial begin
        last_rd = '0;
        test_reset();
        test_basic();
        test_byte_enable();
        test_wait_params();
        test_reset_abort();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_drain outstanding got=%0d want=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
